// File: rtl/env_vca_pkg.sv
// Shared synth voice package: FSM encoding and default datapath widths
// used by the envelope generator and the VCA stage.
package env_vca_pkg;

  localparam int def_nbit_data = 6;
  localparam int def_nbit_smp  = 12;
  localparam int def_nbit_acc  = def_nbit_smp + def_nbit_data;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } vca_state_t;

  // Accumulator width that can hold any sample x envelope product.
  function automatic int acc_width(input int nbit_smp, input int nbit_data);
    return nbit_smp + nbit_data;
  endfunction

endpackage

// File: rtl/env_vca_if.sv
// Sample/envelope bus between the oscillator/envelope side and the VCA,
// plus the scaled-sample outputs toward the mixer.
interface env_vca_if
  import env_vca_pkg::*;
#(
  parameter int nbit_data = def_nbit_data,
  parameter int nbit_smp  = def_nbit_smp
);

  logic signed [nbit_smp-1:0]  smp_in;
  logic                        smp_valid;
  logic        [nbit_data-1:0] env_in;
  logic                        env_on;
  logic signed [nbit_smp-1:0]  smp_out;
  logic                        smp_out_valid;
  logic                        busy;
  logic                        ovr;

  modport master (
    output smp_in, smp_valid, env_in, env_on,
    input  smp_out, smp_out_valid, busy, ovr
  );

  modport slave (
    input  smp_in, smp_valid, env_in, env_on,
    output smp_out, smp_out_valid, busy, ovr
  );

endinterface

// File: rtl/env_vca_shmul.sv
// Serial shift-add multiplier: signed sample times unsigned envelope,
// one envelope bit per step, LSB first. Result is the floored product
// divided by 2^nbit_data, available combinationally on the last step.
module env_vca_shmul
  import env_vca_pkg::*;
#(
  parameter int nbit_data = def_nbit_data,
  parameter int nbit_smp  = def_nbit_smp
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        load,
  input  logic                        step,
  input  logic signed [nbit_smp-1:0]  smp_in,
  input  logic        [nbit_data-1:0] env_in,
  output logic signed [nbit_smp-1:0]  result,
  output logic                        last
);

  localparam int nbit_acc = acc_width(nbit_smp, nbit_data);
  localparam int nbit_cnt = (nbit_data > 1) ? $clog2(nbit_data) : 1;

  logic signed [nbit_smp-1:0]  smp_r;
  logic        [nbit_data-1:0] env_r;
  logic signed [nbit_acc-1:0]  acc;
  logic signed [nbit_acc-1:0]  acc_next;
  logic signed [nbit_acc-1:0]  addend;
  logic        [nbit_cnt-1:0]  cnt;

  // Partial product for the current envelope bit and the running sum.
  always_comb begin
    addend = '0;
    if (env_r[cnt])
      addend = $signed({{nbit_data{smp_r[nbit_smp-1]}}, smp_r}) <<< cnt;
    acc_next = acc + addend;
  end

  // Dropping the low nbit_data bits of a two's-complement sum is a floor.
  assign result = acc_next[nbit_acc-1:nbit_data];
  assign last   = (cnt == nbit_cnt'(nbit_data - 1));

  // Operand capture on load, accumulate and advance the bit counter on step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_r <= '0;
      env_r <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      smp_r <= smp_in;
      env_r <= env_in;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/env_vca.sv
// Envelope-controlled amplifier: scales each oscillator sample by the
// envelope level and strobes the result toward the mixer/DAC path.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int nbit_data = def_nbit_data,
  parameter int nbit_smp  = def_nbit_smp
) (
  input  logic       clk,
  input  logic       rstn,
  env_vca_if.slave   bus
);

  vca_state_t state;
  vca_state_t state_nxt;

  logic                        load;
  logic                        step;
  logic                        last;
  logic                        busy_c;
  logic                        valid_c;
  logic        [nbit_data-1:0] env_gated;
  logic signed [nbit_smp-1:0]  result;
  logic signed [nbit_smp-1:0]  smp_out_r;
  logic                        ovr_r;

  // A silent voice multiplies by zero regardless of the level input.
  assign env_gated = bus.env_on ? bus.env_in : '0;

  env_vca_shmul #(
    .nbit_data (nbit_data),
    .nbit_smp  (nbit_smp)
  ) u_shmul (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .step   (step),
    .smp_in (bus.smp_in),
    .env_in (env_gated),
    .result (result),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: accept from IDLE or DONE, run nbit_data steps in MUL.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.smp_valid ? MUL : IDLE;
      MUL:     state_nxt = last ? DONE : MUL;
      DONE:    state_nxt = bus.smp_valid ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state controls and status outputs.
  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    busy_c  = 1'b0;
    valid_c = 1'b0;
    case (state)
      IDLE: load = bus.smp_valid;
      MUL: begin
        step   = 1'b1;
        busy_c = 1'b1;
      end
      DONE: begin
        valid_c = 1'b1;
        load    = bus.smp_valid;
      end
      default: ;
    endcase
  end

  // Result register and overrun flag for strobes that arrive mid-multiply.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_out_r <= '0;
      ovr_r     <= 1'b0;
    end else begin
      ovr_r <= step & bus.smp_valid;
      if (step && last)
        smp_out_r <= result;
    end
  end

  assign bus.smp_out       = smp_out_r;
  assign bus.ovr           = ovr_r;
  assign bus.busy          = busy_c;
  assign bus.smp_out_valid = valid_c;

endmodule
